// File: rtl/output_port_allocator_pkg.sv
// rtl/output_port_allocator_pkg.sv - shared router flit codes, port indices and allocator state type
package output_port_allocator_pkg;

    // Head-flit type codes shared by all router blocks
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    // Input port indices (bit positions in req/empty/grant/rd_en)
    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// rtl/output_port_allocator_rr_arbiter.sv - combinational round-robin picker starting after ptr
module rr_arbiter #(
    parameter int NPORTS = 5,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] i_eligible,
    input  logic [PW-1:0]     i_ptr,
    output logic [NPORTS-1:0] o_winner,
    output logic              o_any
);

    // Rotate so that port ptr+1 lands at bit 0, take the lowest set bit,
    // then rotate the one-hot back into port order.
    logic [PW:0]       w_shift;
    logic [NPORTS-1:0] w_rot;
    logic [NPORTS-1:0] w_rot_oh;

    assign w_shift  = {1'b0, i_ptr} + {{PW{1'b0}}, 1'b1};
    assign w_rot    = NPORTS'({i_eligible, i_eligible} >> w_shift);
    assign w_rot_oh = w_rot & (~w_rot + NPORTS'(1));
    assign o_winner = NPORTS'(({w_rot_oh, w_rot_oh} << w_shift) >> NPORTS);
    assign o_any    = |i_eligible;

endmodule

// File: rtl/output_port_allocator.sv
// rtl/output_port_allocator.sv - per-output-port packet-locking switch allocator with credit flow control
module output_port_allocator
    import output_port_allocator_pkg::*;
#(
    parameter int NPORTS  = 5,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NPORTS-1:0]     i_req,
    input  logic [NPORTS-1:0]     i_empty,
    input  logic [3*NPORTS-1:0]   i_flit_id,
    input  logic                  i_credit_in,
    output logic [NPORTS-1:0]     o_grant,
    output logic [NPORTS-1:0]     o_rd_en,
    output logic                  o_valid_out,
    output logic [CW-1:0]         o_credit_cnt
);

    localparam int PW = $clog2(NPORTS);

    alloc_state_t      r_state, w_state_nxt;
    logic [NPORTS-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]     r_ptr, w_ptr_nxt;
    logic [CW-1:0]     r_credit_cnt, w_credit_nxt;

    logic [NPORTS-1:0] w_is_header;
    logic [NPORTS-1:0] w_is_tail;
    logic [NPORTS-1:0] w_eligible;
    logic [NPORTS-1:0] w_win_oh;
    logic [NPORTS-1:0] w_rd_en;
    logic [PW-1:0]     w_win_idx;
    logic              w_win_any;
    logic              w_has_credit;
    logic              w_valid;
    logic              w_tail_xfer;

    // Decode each FIFO's head flit type
    always_comb begin
        w_is_header = '0;
        w_is_tail   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_is_header[i] = (i_flit_id[3*i +: 3] == HEADER);
            w_is_tail[i]   = (i_flit_id[3*i +: 3] == TAIL);
        end
    end

    assign w_eligible = i_req & ~i_empty & w_is_header;

    rr_arbiter #(
        .NPORTS (NPORTS),
        .PW     (PW)
    ) u_rr_arbiter (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_winner   (w_win_oh),
        .o_any      (w_win_any)
    );

    // One-hot winner to index, so ptr remembers who was served last
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_win_oh[i]) begin
                w_win_idx = PW'(i);
            end
        end
    end

    // Pop only the owner, only with a downstream slot free, never while in reset
    assign w_has_credit = (r_credit_cnt != '0);
    assign w_rd_en      = (i_rst && (r_state == ST_LOCKED) && w_has_credit)
                          ? (r_grant & ~i_empty) : '0;
    assign w_valid      = |w_rd_en;
    assign w_tail_xfer  = |(w_rd_en & w_is_tail);

    // Next state: arbitrate in IDLE, hold the lock until the tail leaves
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_grant_nxt = w_win_oh;
                    w_ptr_nxt   = w_win_idx;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_tail_xfer) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Credit count: a send consumes, a return refills, a surplus return is dropped
    always_comb begin
        w_credit_nxt = r_credit_cnt;
        case ({w_valid, i_credit_in})
            2'b10:   w_credit_nxt = r_credit_cnt - CW'(1);
            2'b01:   if (r_credit_cnt != CW'(CREDITS)) w_credit_nxt = r_credit_cnt + CW'(1);
            default: w_credit_nxt = r_credit_cnt;
        endcase
    end

    // State, grant, priority pointer and credit registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_ptr        <= PW'(NPORTS - 1);
            r_credit_cnt <= CW'(CREDITS);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_ptr        <= w_ptr_nxt;
            r_credit_cnt <= w_credit_nxt;
        end
    end

    assign o_grant      = r_grant;
    assign o_rd_en      = w_rd_en;
    assign o_valid_out  = w_valid;
    assign o_credit_cnt = r_credit_cnt;

endmodule

// File: tb/tb_output_port_allocator.sv
// tb/tb_output_port_allocator.sv - directed scoreboard bench for output_port_allocator
module tb_output_port_allocator;
    import output_port_allocator_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  empty;
    logic [14:0] flit_id;
    logic        credit_in;
    logic [4:0]  grant;
    logic [4:0]  rd_en;
    logic        valid_out;
    logic [2:0]  credit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [4:0] grant;
        logic [4:0] rd_en;
        logic       valid;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];

    output_port_allocator #(
        .NPORTS  (5),
        .CREDITS (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_empty      (empty),
        .i_flit_id    (flit_id),
        .i_credit_in  (credit_in),
        .o_grant      (grant),
        .o_rd_en      (rd_en),
        .o_valid_out  (valid_out),
        .o_credit_cnt (credit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic set_fid(input int p, input logic [2:0] code);
        flit_id[3*p +: 3] = code;
    endtask

    task automatic quiet();
        req       = '0;
        empty     = '1;
        flit_id   = '0;
        credit_in = 1'b0;
    endtask

    task automatic randomize_inputs();
        req       = 5'($urandom);
        empty     = 5'($urandom);
        flit_id   = 15'($urandom);
        credit_in = 1'($urandom);
    endtask

    // Queue expectations for this cycle, check them mid-cycle, then advance one edge
    task automatic cyc(input string tag, input logic [4:0] g, input logic [4:0] rd, input logic [2:0] cnt);
        exp_t e;
        exp_t o;
        e.tag   = tag;
        e.grant = g;
        e.rd_en = rd;
        e.valid = |rd;
        e.cnt   = cnt;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        n_tests++;
        assert (grant === o.grant) else begin
            n_fail++;
            $error("FAIL %s grant: observed %b expected %b", o.tag, grant, o.grant);
        end
        n_tests++;
        assert (rd_en === o.rd_en) else begin
            n_fail++;
            $error("FAIL %s rd_en: observed %b expected %b", o.tag, rd_en, o.rd_en);
        end
        n_tests++;
        assert (valid_out === o.valid) else begin
            n_fail++;
            $error("FAIL %s valid_out: observed %b expected %b", o.tag, valid_out, o.valid);
        end
        n_tests++;
        assert (credit_cnt === o.cnt) else begin
            n_fail++;
            $error("FAIL %s credit_cnt: observed %0d expected %0d", o.tag, credit_cnt, o.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b0;
        randomize_inputs();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            randomize_inputs();
            cyc("reset", 5'b00000, 5'b00000, 3'd4);
        end
        rst = 1'b1;
        quiet();
        cyc("post_reset", 5'b00000, 5'b00000, 3'd4);

        // Single 3-flit packet on port 2, no credit return
        req[2] = 1'b1; empty[2] = 1'b0; set_fid(2, HEADER);
        cyc("sp_arb",  5'b00000, 5'b00000, 3'd4);
        cyc("sp_hdr",  5'b00100, 5'b00100, 3'd4);
        set_fid(2, PAYLOAD);
        cyc("sp_pay",  5'b00100, 5'b00100, 3'd3);
        set_fid(2, TAIL);
        cyc("sp_tail", 5'b00100, 5'b00100, 3'd2);
        quiet();
        cyc("sp_done", 5'b00000, 5'b00000, 3'd1);

        // Credit return up to full, then a surplus credit that must be dropped
        credit_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc("cr_ret", 5'b00000, 5'b00000, 3'(k + 1));
        end
        cyc("cr_sat",  5'b00000, 5'b00000, 3'd4);
        credit_in = 1'b0;
        cyc("cr_hold", 5'b00000, 5'b00000, 3'd4);

        // Round-robin between ports 1 and 3 from a fresh reset
        rst = 1'b0;
        cyc("rr_rst", 5'b00000, 5'b00000, 3'd4);
        rst = 1'b1;
        req[1] = 1'b1; req[3] = 1'b1; empty[1] = 1'b0; empty[3] = 1'b0;
        set_fid(1, HEADER); set_fid(3, HEADER);
        cyc("rr_arb1",  5'b00000, 5'b00000, 3'd4);
        credit_in = 1'b1;
        cyc("rr_p1_h",  5'b00010, 5'b00010, 3'd4);
        set_fid(1, TAIL);
        cyc("rr_p1_t",  5'b00010, 5'b00010, 3'd4);
        credit_in = 1'b0; set_fid(1, HEADER);
        cyc("rr_arb2",  5'b00000, 5'b00000, 3'd4);
        credit_in = 1'b1;
        cyc("rr_p3_h",  5'b01000, 5'b01000, 3'd4);
        set_fid(3, TAIL);
        cyc("rr_p3_t",  5'b01000, 5'b01000, 3'd4);
        credit_in = 1'b0; set_fid(3, HEADER);
        cyc("rr_arb3",  5'b00000, 5'b00000, 3'd4);
        credit_in = 1'b1;
        cyc("rr_p1b_h", 5'b00010, 5'b00010, 3'd4);
        set_fid(1, TAIL);
        cyc("rr_p1b_t", 5'b00010, 5'b00010, 3'd4);
        quiet();
        cyc("rr_done",  5'b00000, 5'b00000, 3'd4);

        // Credit exhaustion: 6-flit packet on port 0
        req[0] = 1'b1; empty[0] = 1'b0; set_fid(0, HEADER);
        cyc("ce_arb",   5'b00000, 5'b00000, 3'd4);
        cyc("ce_pop1",  5'b00001, 5'b00001, 3'd4);
        set_fid(0, PAYLOAD);
        cyc("ce_pop2",  5'b00001, 5'b00001, 3'd3);
        cyc("ce_pop3",  5'b00001, 5'b00001, 3'd2);
        cyc("ce_pop4",  5'b00001, 5'b00001, 3'd1);
        cyc("ce_stall", 5'b00001, 5'b00000, 3'd0);
        credit_in = 1'b1;
        cyc("ce_cred",  5'b00001, 5'b00000, 3'd0);
        credit_in = 1'b0;
        cyc("ce_pop5",  5'b00001, 5'b00001, 3'd1);
        set_fid(0, TAIL); credit_in = 1'b1;
        cyc("ce_stall2", 5'b00001, 5'b00000, 3'd0);
        credit_in = 1'b0;
        cyc("ce_tail",  5'b00001, 5'b00001, 3'd1);
        quiet();
        cyc("ce_done",  5'b00000, 5'b00000, 3'd0);
        credit_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc("ce_ret", 5'b00000, 5'b00000, 3'(k));
        end
        credit_in = 1'b0;
        cyc("ce_full",  5'b00000, 5'b00000, 3'd4);

        // Bubble mid-packet on port 2 while port 4 waits with a header
        req[2] = 1'b1; empty[2] = 1'b0; set_fid(2, HEADER);
        cyc("bl_arb",  5'b00000, 5'b00000, 3'd4);
        cyc("bl_hdr",  5'b00100, 5'b00100, 3'd4);
        set_fid(2, PAYLOAD); empty[2] = 1'b1;
        req[4] = 1'b1; empty[4] = 1'b0; set_fid(4, HEADER);
        cyc("bl_bub1", 5'b00100, 5'b00000, 3'd3);
        cyc("bl_bub2", 5'b00100, 5'b00000, 3'd3);
        empty[2] = 1'b0;
        cyc("bl_pay1", 5'b00100, 5'b00100, 3'd3);
        cyc("bl_pay2", 5'b00100, 5'b00100, 3'd2);
        set_fid(2, TAIL);
        cyc("bl_tail", 5'b00100, 5'b00100, 3'd1);
        req[2] = 1'b0; empty[2] = 1'b1; credit_in = 1'b1;
        cyc("bl_p4_arb", 5'b00000, 5'b00000, 3'd0);
        cyc("bl_p4_h",   5'b10000, 5'b10000, 3'd1);
        set_fid(4, TAIL);
        cyc("bl_p4_t",   5'b10000, 5'b10000, 3'd1);
        quiet(); credit_in = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cyc("bl_ret", 5'b00000, 5'b00000, 3'(k));
        end
        credit_in = 1'b0;
        cyc("bl_full", 5'b00000, 5'b00000, 3'd4);

        // Mid-packet reset on port 3, then ports 0 and 4 compete
        req[3] = 1'b1; empty[3] = 1'b0; set_fid(3, HEADER);
        cyc("mr_arb", 5'b00000, 5'b00000, 3'd4);
        cyc("mr_hdr", 5'b01000, 5'b01000, 3'd4);
        set_fid(3, PAYLOAD);
        cyc("mr_pay", 5'b01000, 5'b01000, 3'd3);
        rst = 1'b0;
        cyc("mr_rst", 5'b01000, 5'b00000, 3'd2);
        rst = 1'b1;
        quiet();
        req[0] = 1'b1; req[4] = 1'b1; empty[0] = 1'b0; empty[4] = 1'b0;
        set_fid(0, HEADER); set_fid(4, HEADER);
        cyc("mr_after", 5'b00000, 5'b00000, 3'd4);
        cyc("mr_p0_h",  5'b00001, 5'b00001, 3'd4);
        set_fid(0, TAIL);
        cyc("mr_p0_t",  5'b00001, 5'b00001, 3'd3);
        req[0] = 1'b0; empty[0] = 1'b1;
        cyc("mr_arb4",  5'b00000, 5'b00000, 3'd2);
        cyc("mr_p4_h",  5'b10000, 5'b10000, 3'd2);
        set_fid(4, TAIL);
        cyc("mr_p4_t",  5'b10000, 5'b10000, 3'd1);
        quiet();
        cyc("mr_done",  5'b00000, 5'b00000, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Per-output-port switch allocator for the mesh router: consumes the direction requests that each input port's LBDR unit produces for its head-of-line header flit. It arbitrates among input ports round-robin and locks the winner for the whole packet, header to tail. It drives FIFO pops and crossbar select under credit-based flow control toward the downstream router. One instance sits on each of the five output ports (L, N, E, W, S).

## Interface
- `NPORTS`, 5, number of input ports; bit order L=0, N=1, E=2, W=3, S=4.
- `CREDITS`, 4, downstream input-buffer depth in flits.
- `CW`, `$clog2(CREDITS+1)`, credit counter width.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  NPORTS  `req[i]`: LBDR of input i selects this output port.
- `empty`  in  NPORTS  `empty[i]`: input FIFO i empty.
- `flit_id`  in  3*NPORTS  head flit type of FIFO i, slice `[3i+2:3i]`.
- `credit_in`  in  1  one-cycle pulse; downstream freed one slot.
- `grant`  out  NPORTS  registered one-hot owner of this output; 0 when free.
- `rd_en`  out  NPORTS  pop strobe to FIFO i; also crossbar select.
- `valid_out`  out  1  a flit crosses to the downstream link this cycle.
- `credit_cnt`  out  CW  registered count of available downstream slots.

## Operation
- Flit types use the shared `HEADER` / `PAYLOAD` / `TAIL` codes. A packet is one HEADER, zero or more PAYLOAD flits, then one TAIL, so the minimum packet is 2 flits.
- The FSM has two states, IDLE and LOCKED.
- IDLE:
  - Port i is eligible when `req[i] & ~empty[i] & flit_id[i]==HEADER`.
  - The winner is the first eligible port scanning from `ptr+1` upward, with wrap-around.
  - When there is a winner: `grant <= onehot(winner)`, `ptr <= winner`, go to LOCKED.
  - With no eligible port, state and ptr hold.
- LOCKED, with g as the granted port:
  - `rd_en[g] = ~empty[g] & (credit_cnt != 0)`. All other `rd_en` bits are 0.
  - `req` and the other ports are ignored.
  - When a TAIL flit transfers (`rd_en[g] & flit_id[g]==TAIL`): `grant <= 0`, go to IDLE.
- `rd_en` is combinational from registered state plus `empty`/`flit_id`. It is always 0 in IDLE.
- `valid_out = |rd_en`.
- Credits update as `credit_cnt <= credit_cnt - valid_out + credit_in`.
  - A simultaneous send and credit leaves the count unchanged.
  - A `credit_in` arriving while `credit_cnt==CREDITS` with no send is dropped; the count saturates. This is a protocol error, and the bench flags it.
- Reset (`rst==0` at a clock edge), including in the middle of a packet:
  - state IDLE, `grant=0`, `ptr=NPORTS-1` (port 0 has first priority), `credit_cnt=CREDITS`.
  - `rd_en` and `valid_out` are 0 during reset regardless of inputs.

## Timing
- Arbitration latency: an eligible header visible at edge t produces `grant` at t+1. The first `rd_en` (header pop) comes in the cycle after t+1's edge if a credit is available.
- Throughput while LOCKED is one flit per cycle. It stalls only on `empty[g]` or `credit_cnt==0`, and grant is held through stalls.
- Turnaround: a TAIL popped in cycle c gives `grant=0` at c+1, with IDLE arbitrating in cycle c+1. The next grant is visible at c+2, so there is a 1-cycle bubble between packets.
- A credit returned in cycle c makes the next pop possible in cycle c+1.
- `credit_cnt` never goes below 0, because `rd_en` is gated on it.

## Structure
- The flit-type codes (`HEADER`, `PAYLOAD`, `TAIL`) and the port index constants L/N/E/W/S live in the shared parameters include used by the router blocks, and are not redefined here.
- One sub-module, `rr_arbiter`, is natural: an `NPORTS`-wide round-robin priority picker. Its inputs are the eligible vector and `ptr`; its outputs are a one-hot winner and an any-bit. It is purely combinational, and the allocator owns `ptr`.
- The allocator holds the FSM, grant register, credit counter and `rd_en` gating.

## Test plan
- Reset: hold `rst=0` for 2 cycles with random inputs, then release. Required: `grant=0`, `rd_en=0`, `valid_out=0`, `credit_cnt=4`.
- Single packet: port 2 requests with a 3-flit packet (H, P, T), FIFO non-empty, no `credit_in`. Required:
  - `grant=5'b00100` one cycle later.
  - `rd_en[2]` high for 3 consecutive cycles.
  - `credit_cnt` goes 4→3→2→1.
  - `grant=0` the cycle after the tail.
- Round-robin: ports 1 and 3 both request from reset with 2-flit packets, then both request again. Required grant order: 1, 3, 1. Credits are returned each cycle.
- Credit exhaustion: 6-flit packet on port 0 with no `credit_in`. Required:
  - 4 pops, then `rd_en=0` while `grant` is held.
  - A `credit_in` pulse gives exactly one more pop the next cycle.
- Bubble and lock: `empty[g]` goes high for 2 cycles mid-packet while port 4 requests with a header. Required: `rd_en=0` in both cycles, `grant` unchanged, port 4 is not granted until after the tail.
- Mid-packet reset: assert `rst=0` after the 2nd flit of a 4-flit packet. Required: the next cycle shows `grant=0`, `credit_cnt=4`, `rd_en=0`, and the next arbitration favours port 0.
